// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the two-port data memory arbiter.
//   arb_state_e : access sequencer states (IDLE -> ISSUE -> WAIT -> IDLE)
//   dmem_req_t  : one latched request at the default 32-bit geometry
//   PORT_CORE / PORT_DMA : requester indices into the per-port vectors
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  // Describes a request at the default geometry (32-bit address/data).
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } dmem_req_t;

  localparam int PORT_CORE = 0;
  localparam int PORT_DMA  = 1;

endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: two-way grant logic, purely combinational.
//   req        in  [1:0]  request per port
//   last_grant in  1      port granted by the previous accepted request
//   grant      out [1:0]  one-hot winner, or 0 when nobody requests
// With CORE_PRIO != 0 the core port always wins a conflict; otherwise the
// port that was not granted last time wins.
module arb_rr2
  import dmem_arb_pkg::*;
#(
  parameter int CORE_PRIO = 0
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant[PORT_CORE] = 1'b1;
      2'b10:   grant[PORT_DMA]  = 1'b1;
      2'b11: begin
        if (CORE_PRIO != 0 || last_grant) grant[PORT_CORE] = 1'b1;
        else                              grant[PORT_DMA]  = 1'b1;
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port fixed-latency data memory between the
// core memory stage (port 0) and a DMA/debug master (port 1).
// Each access runs accept -> issue -> wait for latency -> respond; while an
// access is in flight both ports see p_req_ready low, which stalls the core.
//   clk, arst_n            clock, asynchronous active-low reset
//   p_req_valid/p_req_ready per-port request handshake
//   p_we/p_addr/p_wdata/p_mask per-port request fields
//   p_rsp_valid, p_rdata   one-cycle response pulse to the owner, shared read data
//   mem_req/we/addr/wdata/mask  memory command (one-cycle strobe, fields held)
//   mem_rdata              memory read data, valid MEM_LATENCY cycles after mem_req
//   busy                   high whenever an access is in flight
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter  int ADDR_WIDTH  = 32,
  parameter  int DATA_WIDTH  = 32,
  parameter  int MEM_LATENCY = 1,
  parameter  int CORE_PRIO   = 0,
  localparam int MASK_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic [1:0]                 p_req_valid,
  output logic [1:0]                 p_req_ready,
  input  logic [1:0]                 p_we,
  input  logic [1:0][ADDR_WIDTH-1:0] p_addr,
  input  logic [1:0][DATA_WIDTH-1:0] p_wdata,
  input  logic [1:0][MASK_WIDTH-1:0] p_mask,
  output logic [1:0]                 p_rsp_valid,
  output logic [DATA_WIDTH-1:0]      p_rdata,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  output logic [MASK_WIDTH-1:0]      mem_mask,
  input  logic [DATA_WIDTH-1:0]      mem_rdata,
  output logic                       busy
);

  arb_state_e            state_reg;
  logic [3:0]            cnt_reg;
  logic                  owner_reg;
  logic                  last_grant_reg;
  logic                  mem_req_reg;
  logic                  mem_we_reg;
  logic [ADDR_WIDTH-1:0] mem_addr_reg;
  logic [DATA_WIDTH-1:0] mem_wdata_reg;
  logic [MASK_WIDTH-1:0] mem_mask_reg;
  logic [1:0]            rsp_valid_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;

  logic [1:0] grant;
  logic       accept;
  logic       acc_port;

  arb_rr2 #(.CORE_PRIO(CORE_PRIO)) u_arb (
    .req        (p_req_valid),
    .last_grant (last_grant_reg),
    .grant      (grant)
  );

  // Only the winner sees ready, and only while no access is in flight.
  assign p_req_ready = (state_reg == IDLE) ? grant : 2'b00;
  assign accept      = |(p_req_valid & p_req_ready);
  assign acc_port    = p_req_ready[PORT_DMA];

  // The memory command fields are loaded at accept time so that they are
  // already registered during ISSUE, and simply hold afterwards.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_mask_reg   <= '0;
      rsp_valid_reg  <= 2'b00;
      rdata_reg      <= '0;
    end else begin
      mem_req_reg   <= 1'b0;
      rsp_valid_reg <= 2'b00;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            mem_req_reg    <= 1'b1;
            mem_we_reg     <= p_we[acc_port];
            mem_addr_reg   <= p_addr[acc_port];
            mem_wdata_reg  <= p_wdata[acc_port];
            mem_mask_reg   <= p_mask[acc_port];
            owner_reg      <= acc_port;
            last_grant_reg <= acc_port;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_reg   <= 4'(MEM_LATENCY - 1);
          state_reg <= WAIT;
        end
        WAIT: begin
          if (cnt_reg == 4'd0) begin
            // mem_rdata is trusted only in this exact cycle.
            rdata_reg                <= mem_rdata;
            rsp_valid_reg[owner_reg] <= 1'b1;
            state_reg                <= IDLE;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mem_req     = mem_req_reg;
  assign mem_we      = mem_we_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_wdata   = mem_wdata_reg;
  assign mem_mask    = mem_mask_reg;
  assign p_rsp_valid = rsp_valid_reg;
  assign p_rdata     = rdata_reg;
  assign busy        = (state_reg != IDLE);

`ifndef SYNTHESIS
  // Requesters must hold valid and fields stable until accepted.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req_stable
      a_req_stable: assert property (@(posedge clk) disable iff (!arst_n)
        (p_req_valid[gi] && !p_req_ready[gi]) |=>
          (p_req_valid[gi] && $stable(p_we[gi]) && $stable(p_addr[gi]) &&
           $stable(p_wdata[gi]) && $stable(p_mask[gi])));
    end
  endgenerate

  a_no_double_req: assert property (@(posedge clk) disable iff (!arst_n)
    mem_req |=> !mem_req);
`endif

endmodule
